alu_issue_skid: RTL and testbench
=================================

Name: alu_issue_skid

Overview:
- Registered issue stage directly upstream of the single-cycle ALU in the RISC-V datapath.
- Accepts decoded operations (ALU opcode, two operands, destination tag) from decode over a valid/ready handshake.
- Buffers them in a 2-entry skid buffer and presents one registered operation at a time to the ALU's opc/a/b inputs.
- Breaks the decode-to-ALU combinational path; absorbs one cycle of downstream backpressure without a combinational ready path.

Parameters:
- N, 32, operand width; matches ALU width.
- OPCW, 3, ALU opcode width.
- TAGW, 5, destination register tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all buffered operations (branch redirect).
- in_valid  input  1  decode offers an operation.
- in_ready  output  1  stage can accept; driven only from registered state.
- in_opc  input  OPCW  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
- in_a  input  N  operand A, signed.
- in_b  input  N  operand B, signed.
- in_rd  input  TAGW  destination tag.
- out_valid  output  1  operation presented to ALU is valid.
- out_ready  input  1  ALU/writeback consumes the operation this cycle.
- out_opc  output  OPCW  to ALU opc.
- out_a  output  N  to ALU a.
- out_b  output  N  to ALU b.
- out_rd  output  TAGW  tag travelling alongside the ALU result.
- occupancy  output  2  buffered entries, 0..2.

Behaviour:
- Storage:
  - main register (drives out_*), main_v.
  - skid register, skid_v.
- Reset (async, rst=1):
  - main_v=0, skid_v=0, all data registers 0.
  - out_valid=0, out_opc/a/b=0, out_rd=0, occupancy=0, in_ready=1.
- Derived signals:
  - in_ready = ~skid_v.
  - out_valid = main_v.
  - occupancy = main_v + skid_v.
- Handshake events:
  - Input accept = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - Data is sampled only on accept.
  - out_* holds stable while out_valid & ~out_ready.
- Latency: operation accepted at edge k appears on out_* after edge k (1 cycle); no same-cycle pass-through.
- Per-edge update, checked in priority order:
  - flush=1: main_v=0 and skid_v=0; a same-cycle input is dropped, not accepted. Data registers may keep stale values.
  - Empty (main_v=0, skid_v=0): accept loads main.
  - main only, fire & accept: main <- input.
  - main only, fire & ~accept: main_v=0.
  - main only, ~fire & accept: skid <- input, skid_v=1 (in_ready drops next cycle).
  - main+skid (in_ready=0, no accept), fire: main <- skid, skid_v=0.
  - main+skid, ~fire: hold.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Full (occupancy=2): in_ready=0; in_valid ignored.
- Empty: out_valid=0; out_ready ignored.
- Opcodes:
  - Opcode 110/111 passes through unmodified; the stage does not check it.
  - Operands and opcode pass bit-exact, with no sign or width manipulation.
- Reset mid-operation: all entries lost immediately, asynchronously.
- Throughput: 1 op/cycle sustained when out_ready is held 1.

Test Plan:
- Reset then idle: rst pulse -> out_valid=0, occupancy=0, in_ready=1; after release, in_valid=0 for 3 cycles -> unchanged.
- Single op: in_opc=001, a=7, b=3, rd=4, out_ready=1 -> next cycle out_valid=1, out_opc=001, out_a=7, out_b=3, out_rd=4; ALU w=4. Following cycle out_valid=0.
- Backpressure/skid: out_ready=0, send ops A(a=1) and B(a=2) on consecutive cycles -> occupancy=2, in_ready=0, out_a=1 held. A third op C is offered and not accepted. Raise out_ready -> out_a=1, then 2, then C accepted.
- Streaming: 16 back-to-back ops (a=i), out_ready=1 -> out_a sequence 0..15 on consecutive cycles, no bubbles, no loss.
- Flush: occupancy=2, flush=1 with in_valid=1 (a=99) -> next cycle occupancy=0, out_valid=0, op 99 never appears.
- Async reset mid-stream: rst asserted between clock edges with occupancy=2 -> out_valid=0 and in_ready=1 immediately, without waiting for clk.

Source files
------------

// File: rtl/alu_issue_skid.sv
// Registered issue stage in front of the single-cycle ALU: a 2-entry skid buffer
// that cuts the decode-to-ALU path and keeps in_ready purely registered.
module alu_issue_skid #(
    parameter int N    = 32,
    parameter int OPCW = 3,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPCW-1:0] in_opc,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic [TAGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPCW-1:0] out_opc,
    output logic [N-1:0]    out_a,
    output logic [N-1:0]    out_b,
    output logic [TAGW-1:0] out_rd,
    output logic [1:0]      occupancy
);

    localparam int OPW = OPCW + N + N + TAGW;

    logic [OPW-1:0] main_q, main_d;
    logic [OPW-1:0] skid_q, skid_d;
    logic           main_v_q, main_v_d;
    logic           skid_v_q, skid_v_d;
    logic [OPW-1:0] in_op_s;
    logic           accept_s;
    logic           fire_s;

    assign in_op_s  = {in_opc, in_a, in_b, in_rd};
    assign accept_s = in_valid & ~skid_v_q;
    assign fire_s   = main_v_q & out_ready;

    // Next-state selection for both entries; flush dominates and drops any same-cycle input.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (accept_s) begin
                        main_d   = in_op_s;
                        main_v_d = 1'b1;
                    end else begin
                        main_v_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (fire_s && accept_s) begin
                        main_d = in_op_s;
                    end else if (fire_s) begin
                        main_v_d = 1'b0;
                    end else if (accept_s) begin
                        skid_d   = in_op_s;
                        skid_v_d = 1'b1;
                    end else begin
                        main_v_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (fire_s) begin
                        main_d   = skid_q;
                        skid_v_d = 1'b0;
                    end else begin
                        skid_v_d = 1'b1;
                    end
                end
                default: begin
                    // Unreachable (skid without main); promote skid so ordering is kept.
                    main_d   = skid_q;
                    main_v_d = 1'b1;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    // Entry and valid registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign {out_opc, out_a, out_b, out_rd} = main_q;

endmodule

// File: tb/tb_alu_issue_skid.sv
// Bench for alu_issue_skid: directed scenarios plus random traffic against a queue model.
module tb_alu_issue_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opc = 3'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_opc;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;

    typedef struct packed {
        logic [2:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    op_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    alu_issue_skid #(.N(32), .OPCW(3), .TAGW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opc(in_opc), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opc(out_opc), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk({tag, "_occ"}, {30'd0, occupancy}, q.size());
        chk({tag, "_rdy"}, {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk({tag, "_opc"}, {29'd0, out_opc}, {29'd0, q[0].opc});
            chk({tag, "_a"}, out_a, q[0].a);
            chk({tag, "_b"}, out_b, q[0].b);
            chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, q[0].rd});
        end
    endtask

    // One clock: model decides from pre-edge inputs, then the edge, then compare at +1.
    task automatic cycle(input string tag);
        bit  acc;
        bit  fire;
        op_t in_op;
        acc   = in_valid && (q.size() < 2) && !flush;
        fire  = (q.size() > 0) && out_ready;
        in_op = '{opc: in_opc, a: in_a, b: in_b, rd: in_rd};
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(in_op);
        end
        check_model(tag);
    endtask

    task automatic drive(input bit v, input logic [2:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid = v;
        in_opc   = opc;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    initial begin
        // Reset and idle
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle("idle");

        // Single op
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 32'd7, 32'd3, 5'd4);
        cycle("single");
        chk("single_opc_c", {29'd0, out_opc}, 32'd1);
        chk("single_a_c", out_a, 32'd7);
        chk("single_b_c", out_b, 32'd3);
        chk("single_rd_c", {27'd0, out_rd}, 32'd4);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        cycle("single_drain");
        chk("single_gone", {31'd0, out_valid}, 32'd0);

        // Backpressure into the skid entry
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'd1, 32'd10, 5'd1);
        cycle("bp_a");
        drive(1'b1, 3'b010, 32'd2, 32'd20, 5'd2);
        cycle("bp_b");
        chk("bp_full_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", out_a, 32'd1);
        drive(1'b1, 3'b100, 32'd3, 32'd30, 5'd3);
        cycle("bp_c_blocked");
        chk("bp_still_a", out_a, 32'd1);
        out_ready = 1'b1;
        cycle("bp_rel1");
        chk("bp_rel1_a", out_a, 32'd2);
        cycle("bp_rel2");
        chk("bp_rel2_a", out_a, 32'd3);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        cycle("bp_drain");

        // Streaming, no bubbles
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'b011, i, ~i, i[4:0]);
            cycle("stream");
            chk("stream_a", out_a, i);
            chk("stream_v", {31'd0, out_valid}, 32'd1);
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        cycle("stream_drain");

        // Flush with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 3'b101, 32'd5, 32'd6, 5'd7);
        cycle("fl_a");
        drive(1'b1, 3'b110, 32'd8, 32'd9, 5'd8);
        cycle("fl_b");
        flush = 1'b1;
        drive(1'b1, 3'b111, 32'd99, 32'd99, 5'd9);
        cycle("flush");
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cycle("post_flush");
            chk("no_99", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom), $urandom, $urandom, 5'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            cycle("rnd");
        end
        flush = 1'b0;

        // Async reset with a full buffer
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'd11, 32'd12, 5'd13);
        cycle("ar_a");
        drive(1'b1, 3'b001, 32'd14, 32'd15, 5'd16);
        cycle("ar_b");
        chk("ar_full", {30'd0, occupancy}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_rdy", {31'd0, in_ready}, 32'd1);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle("ar_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
